bip_acc_unit: RTL

BIP_ACC_UNIT -- requirements
Module: bip_acc_unit

---
 rtl/bip_acc_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/bip_acc_unit.sv
// Accumulator unit: operand/memory loads, a single-cycle ALU with {Z,N,C,V} flags,
// and an iterative shift-add multiplier that stalls further writes while it runs.
module bip_acc_unit #(
  parameter int unsigned NB_BITS = 16,
  parameter int unsigned NB_OPER = 11
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_BITS-1:0] i_data_mem,
  input  logic [NB_OPER-1:0] i_data_ins,
  input  logic [1:0]         i_sel_a,
  input  logic               i_sel_b,
  input  logic               i_wr_acc,
  input  logic [2:0]         i_op,
  output logic [NB_BITS-1:0] o_acc,
  output logic [NB_BITS-1:0] o_data,
  output logic [3:0]         o_flags,
  output logic               o_busy,
  output logic               o_done
);

  localparam int unsigned Msb     = NB_BITS - 1;
  localparam int unsigned CntW    = (NB_BITS > 1) ? $clog2(NB_BITS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NB_BITS - 1);

  typedef enum logic [2:0] {
    OpSub = 3'b000,
    OpAdd = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpSll = 3'b101,
    OpSra = 3'b110,
    OpMul = 3'b111
  } op_e;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e              state_q;
  logic [NB_BITS-1:0]  acc_q;
  logic [3:0]          flags_q;
  logic                busy_q;
  logic                done_q;
  logic [CntW-1:0]     cnt_q;
  logic [NB_BITS-1:0]  mcand_q;
  logic [NB_BITS-1:0]  mplier_q;
  logic [NB_BITS-1:0]  prod_q;

  logic [NB_BITS-1:0]  sext_ins;
  logic [NB_BITS-1:0]  opb;
  logic [NB_BITS:0]    sum;
  logic [NB_BITS-1:0]  alu_res;
  logic                alu_c;
  logic                alu_v;
  logic [NB_BITS-1:0]  prod_step;
  op_e                 op;

  assign op       = op_e'(i_op);
  assign sext_ins = NB_BITS'($signed(i_data_ins));
  assign opb      = i_sel_b ? sext_ins : i_data_mem;
  assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (op)
      OpSub: begin
        sum     = {1'b0, acc_q} - {1'b0, opb};
        alu_res = sum[NB_BITS-1:0];
        // Borrow shows up in the extra top bit; C is its inverse.
        alu_c   = ~sum[NB_BITS];
        alu_v   = (acc_q[Msb] ^ opb[Msb]) & (alu_res[Msb] ^ acc_q[Msb]);
      end
      OpAdd: begin
        sum     = {1'b0, acc_q} + {1'b0, opb};
        alu_res = sum[NB_BITS-1:0];
        alu_c   = sum[NB_BITS];
        alu_v   = ~(acc_q[Msb] ^ opb[Msb]) & (alu_res[Msb] ^ acc_q[Msb]);
      end
      OpAnd: alu_res = acc_q & opb;
      OpOr:  alu_res = acc_q | opb;
      OpXor: alu_res = acc_q ^ opb;
      OpSll: begin
        alu_res = acc_q << 1;
        alu_c   = acc_q[Msb];
      end
      OpSra: begin
        alu_res = {acc_q[Msb], acc_q[Msb:1]};
        alu_c   = acc_q[0];
      end
      OpMul: alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      flags_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_wr_acc) begin
            case (i_sel_a)
              2'b00: begin
                acc_q   <= i_data_mem;
                flags_q <= {i_data_mem == '0, i_data_mem[Msb], flags_q[1:0]};
              end
              2'b01: begin
                acc_q   <= sext_ins;
                flags_q <= {sext_ins == '0, sext_ins[Msb], flags_q[1:0]};
              end
              2'b10: begin
                if (op == OpMul) begin
                  mcand_q  <= acc_q;
                  mplier_q <= opb;
                  prod_q   <= '0;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= StMul;
                end else begin
                  acc_q   <= alu_res;
                  flags_q <= {alu_res == '0, alu_res[Msb], alu_c, alu_v};
                end
              end
              default: ;
            endcase
          end
        end
        StMul: begin
          prod_q   <= prod_step;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          // Last iteration: commit the product directly from the adder output.
          if (cnt_q == CntLast) begin
            acc_q   <= prod_step;
            flags_q <= {prod_step == '0, prod_step[Msb], 2'b00};
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_acc   = acc_q;
  assign o_data  = acc_q;
  assign o_flags = flags_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule
